// File: rtl/ibex_pmp_csr.sv
// ibex_pmp_csr: PMP CSR storage and write-rule stage feeding the PMP checker.
// Holds pmpcfg0-3, pmpaddr0-15 and mseccfg. Applies the entry lock, TOR lock and
// Smepmp MML/MMWP/RLB write rules against the registered (pre-write) state.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   csr_we_i                  CSR write strobe (already privilege/legality gated)
//   csr_addr_i, csr_wdata_i   CSR address and final write data
//   csr_rdata_o, csr_hit_o    combinational read data, address-is-PMP-CSR flag
//   csr_pmp_cfg_o             registered per-entry configs
//   csr_pmp_addr_o            per-entry {pmpaddr read view, 2'b00}
//   csr_pmp_mseccfg_o         registered mml/mmwp/rlb
package ibex_pmp_csr_pkg;
   typedef struct packed {
      logic       lock;
      logic [1:0] mode;
      logic       exec;
      logic       write;
      logic       read;
   } pmp_cfg_t;
   typedef struct packed {
      logic rlb;
      logic mmwp;
      logic mml;
   } pmp_mseccfg_t;
endpackage

module ibex_pmp_csr
   import ibex_pmp_csr_pkg::*;
#(
   parameter int unsigned PMPGranularity = 0,
   parameter int unsigned PMPNumRegions  = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         csr_we_i,
   input  logic [11:0]  csr_addr_i,
   input  logic [31:0]  csr_wdata_i,
   output logic [31:0]  csr_rdata_o,
   output logic         csr_hit_o,
   output pmp_cfg_t     csr_pmp_cfg_o [PMPNumRegions],
   output logic [33:0]  csr_pmp_addr_o [PMPNumRegions],
   output pmp_mseccfg_t csr_pmp_mseccfg_o
);
   // Bits below the grain read as zero; NAPOT sets the bits that encode the grain size.
   localparam logic [31:0] GrainMask = (32'd1 << PMPGranularity) - 32'd1;
   localparam logic [31:0] NapotOnes = (PMPGranularity >= 1) ? (32'd1 << (PMPGranularity - 1)) - 32'd1 : 32'd0;

   // Storage is sized for all 16 entries; unimplemented ones never get written and stay 0.
   pmp_cfg_t          cfg_q [16];
   pmp_cfg_t          cfg_d [16];
   logic [31:0]       addr_q [16];
   logic [31:0]       addr_d [16];
   logic [31:0]       addr_view [16];
   pmp_mseccfg_t      sec_q, sec_d;
   logic [15:0]       locked, lbit;
   logic [16:0]       tor_lock;
   logic [15:0][7:0]  cfg_byte;
   logic [3:0][31:0]  cfg_word;
   logic [7:0]        wb;
   logic              mml_deny;
   logic              hit_cfg, hit_addr, hit_sec, hit_sech;
   logic              cfg_we, addr_we, sec_we;

   assign hit_cfg  = csr_addr_i[11:2] == 10'h0E8;
   assign hit_addr = csr_addr_i[11:4] == 8'h3B;
   assign hit_sec  = csr_addr_i == 12'h747;
   assign hit_sech = csr_addr_i == 12'h757;
   assign csr_hit_o = hit_cfg | hit_addr | hit_sec | hit_sech;
   assign cfg_we  = csr_we_i & hit_cfg;
   assign addr_we = csr_we_i & hit_addr;
   assign sec_we  = csr_we_i & hit_sec;

   always_comb begin
      for (int unsigned e = 0; e < 16; e++) begin
         lbit[e]      = cfg_q[e].lock;
         locked[e]    = cfg_q[e].lock & ~sec_q.rlb;
         tor_lock[e]  = locked[e] & (cfg_q[e].mode == 2'b01);
         cfg_byte[e]  = {cfg_q[e].lock, 2'b00, cfg_q[e].mode, cfg_q[e].exec, cfg_q[e].write, cfg_q[e].read};
         addr_view[e] = (cfg_q[e].mode == 2'b11) ? (addr_q[e] | NapotOnes) : (addr_q[e] & ~GrainMask);
      end
      tor_lock[16] = 1'b0;
   end

   assign cfg_word = cfg_byte;

   always_comb begin
      sec_d    = sec_q;
      wb       = '0;
      mml_deny = 1'b0;
      if (sec_we) begin
         sec_d.mml  = sec_q.mml | csr_wdata_i[0];
         sec_d.mmwp = sec_q.mmwp | csr_wdata_i[1];
         sec_d.rlb  = (sec_q.rlb | ~|lbit) ? csr_wdata_i[2] : sec_q.rlb;
      end
      for (int unsigned e = 0; e < 16; e++) begin
         wb = csr_wdata_i[8*(e%4) +: 8];
         // Under MML without RLB, new locked entries may not be executable or write-only,
         // except the full LRWX=1111 shared-region encoding.
         mml_deny = sec_q.mml & ~sec_q.rlb & wb[7] & (wb[2] | (~wb[0] & wb[1])) & ~&wb[2:0];
         cfg_d[e] = cfg_q[e];
         if (cfg_we && csr_addr_i[1:0] == 2'(e / 4) && e < PMPNumRegions && !locked[e] && !mml_deny)
            cfg_d[e] = '{lock:  wb[7],
                         mode:  (PMPGranularity >= 1 && wb[4:3] == 2'b10) ? cfg_q[e].mode : wb[4:3],
                         exec:  wb[2],
                         write: wb[1] & (wb[0] | sec_q.mml),
                         read:  wb[0]};
         addr_d[e] = addr_q[e];
         if (addr_we && csr_addr_i[3:0] == 4'(e) && e < PMPNumRegions && !locked[e] && !tor_lock[e+1])
            addr_d[e] = csr_wdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sec_q  <= '0;
         cfg_q  <= '{default: '0};
         addr_q <= '{default: '0};
      end else begin
         sec_q  <= sec_d;
         cfg_q  <= cfg_d;
         addr_q <= addr_d;
      end
   end

   assign csr_rdata_o = hit_cfg  ? cfg_word[csr_addr_i[1:0]] :
                        hit_addr ? addr_view[csr_addr_i[3:0]] :
                        hit_sec  ? {29'd0, sec_q} : 32'd0;

   for (genvar i = 0; i < PMPNumRegions; i++) begin : g_out
      assign csr_pmp_cfg_o[i]  = cfg_q[i];
      assign csr_pmp_addr_o[i] = {addr_view[i], 2'b00};
   end

   assign csr_pmp_mseccfg_o = sec_q;
endmodule

// File: tb/tb_ibex_pmp_csr.sv
// tb_ibex_pmp_csr: directed plus randomized checks of two ibex_pmp_csr configurations
// (G=0/4 entries and G=2/16 entries) against a rule-level reference model.
module tb_ibex_pmp_csr;
   import ibex_pmp_csr_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         we = 1'b0;
   logic [11:0]  addr = '0;
   logic [31:0]  wdata = '0;
   logic [31:0]  rd0, rd1;
   logic         hit0, hit1;
   pmp_cfg_t     cfg0 [4];
   pmp_cfg_t     cfg1 [16];
   logic [33:0]  pa0 [4];
   logic [33:0]  pa1 [16];
   pmp_mseccfg_t sec0, sec1;
   int           total = 0;
   int           bad = 0;

   logic [7:0]  mc [2][16];
   logic [31:0] ma [2][16];
   logic [2:0]  ms [2];

   always #5 clk = ~clk;

   ibex_pmp_csr #(.PMPGranularity(0), .PMPNumRegions(4)) u0 (
      .clk_i(clk), .rst_ni(rst_n), .csr_we_i(we), .csr_addr_i(addr), .csr_wdata_i(wdata),
      .csr_rdata_o(rd0), .csr_hit_o(hit0), .csr_pmp_cfg_o(cfg0), .csr_pmp_addr_o(pa0),
      .csr_pmp_mseccfg_o(sec0));

   ibex_pmp_csr #(.PMPGranularity(2), .PMPNumRegions(16)) u1 (
      .clk_i(clk), .rst_ni(rst_n), .csr_we_i(we), .csr_addr_i(addr), .csr_wdata_i(wdata),
      .csr_rdata_o(rd1), .csr_hit_o(hit1), .csr_pmp_cfg_o(cfg1), .csr_pmp_addr_o(pa1),
      .csr_pmp_mseccfg_o(sec1));

   function automatic int gr(input int k);
      return (k == 0) ? 0 : 2;
   endfunction

   function automatic int nr(input int k);
      return (k == 0) ? 4 : 16;
   endfunction

   function automatic bit mlock(input int k, input int e);
      return mc[k][e][7] && !ms[k][2];
   endfunction

   function automatic logic [31:0] mview(input int k, input int e);
      logic [31:0] v;
      v = ma[k][e];
      for (int j = 0; j < gr(k); j++)
         if (mc[k][e][4:3] == 2'b11) begin
            if (j < gr(k) - 1) v[j] = 1'b1;
         end else v[j] = 1'b0;
      return v;
   endfunction

   function automatic bit mhit(input logic [11:0] a);
      return (a >= 12'h3A0 && a <= 12'h3A3) || (a >= 12'h3B0 && a <= 12'h3BF) || a == 12'h747 || a == 12'h757;
   endfunction

   function automatic logic [31:0] mread(input int k, input logic [11:0] a);
      logic [31:0] r;
      r = '0;
      if (a >= 12'h3A0 && a <= 12'h3A3)
         for (int i = 0; i < 4; i++) r[8*i +: 8] = mc[k][(int'(a) - 'h3A0) * 4 + i];
      else if (a >= 12'h3B0 && a <= 12'h3BF) r = mview(k, int'(a) - 'h3B0);
      else if (a == 12'h747) r = {29'd0, ms[k]};
      return r;
   endfunction

   task automatic mreset();
      for (int k = 0; k < 2; k++) begin
         ms[k] = '0;
         for (int e = 0; e < 16; e++) begin
            mc[k][e] = '0;
            ma[k][e] = '0;
         end
      end
   endtask

   task automatic mwrite(input logic [11:0] a, input logic [31:0] d);
      int e;
      bit any_l;
      logic [7:0] b, nb;
      for (int k = 0; k < 2; k++) begin
         any_l = 0;
         for (int x = 0; x < 16; x++) if (mc[k][x][7]) any_l = 1;
         if (a >= 12'h3A0 && a <= 12'h3A3) begin
            for (int i = 0; i < 4; i++) begin
               e = (int'(a) - 'h3A0) * 4 + i;
               b = d[8*i +: 8];
               if (e >= nr(k) || mlock(k, e)) continue;
               if (ms[k][0] && !ms[k][2] && b[7] && (b[2] || b[1:0] == 2'b10) && b[2:0] != 3'b111) continue;
               nb = b & 8'h9F;
               if (!ms[k][0] && b[1:0] == 2'b10) nb[1] = 1'b0;
               if (gr(k) >= 1 && b[4:3] == 2'b10) nb[4:3] = mc[k][e][4:3];
               mc[k][e] = nb;
            end
         end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
            e = int'(a) - 'h3B0;
            if (e < nr(k) && !mlock(k, e) && !(e + 1 < nr(k) && mlock(k, e + 1) && mc[k][e+1][4:3] == 2'b01))
               ma[k][e] = d;
         end else if (a == 12'h747) begin
            ms[k][0] = ms[k][0] | d[0];
            ms[k][1] = ms[k][1] | d[1];
            if (ms[k][2] || !any_l) ms[k][2] = d[2];
         end
      end
   endtask

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      @(negedge clk);
      we = 1'b1;
      addr = a;
      wdata = d;
      @(negedge clk);
      we = 1'b0;
      mwrite(a, d);
   endtask

   task automatic chk_rd(input logic [11:0] a);
      addr = a;
      #1;
      chk($sformatf("rd0@%h", a), rd0, mread(0, a));
      chk($sformatf("rd1@%h", a), rd1, mread(1, a));
      chk($sformatf("hit0@%h", a), hit0, mhit(a));
      chk($sformatf("hit1@%h", a), hit1, mhit(a));
   endtask

   task automatic rd_is(input logic [11:0] a, input logic [31:0] e0, input logic [31:0] e1);
      addr = a;
      #1;
      chk($sformatf("dir0@%h", a), rd0, e0);
      chk($sformatf("dir1@%h", a), rd1, e1);
   endtask

   task automatic chk_all();
      for (int a = 'h3A0; a <= 'h3A3; a++) chk_rd(12'(a));
      for (int a = 'h3B0; a <= 'h3BF; a++) chk_rd(12'(a));
      chk_rd(12'h747);
      chk_rd(12'h757);
      for (int e = 0; e < 4; e++) begin
         chk($sformatf("cfg0_o[%0d]", e), cfg0[e], {mc[0][e][7], mc[0][e][4:0]});
         chk($sformatf("addr0_o[%0d]", e), pa0[e], {mview(0, e), 2'b00});
      end
      for (int e = 0; e < 16; e++) begin
         chk($sformatf("cfg1_o[%0d]", e), cfg1[e], {mc[1][e][7], mc[1][e][4:0]});
         chk($sformatf("addr1_o[%0d]", e), pa1[e], {mview(1, e), 2'b00});
      end
      chk("sec0_o", sec0, ms[0]);
      chk("sec1_o", sec1, ms[1]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      mreset();
      #2;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [11:0] a;
      logic [31:0] d;
      int r;
      mreset();
      #12;
      chk_all();
      rst_n = 1'b1;
      rd_is(12'h3A0, 32'h0, 32'h0);

      // locked entry keeps its byte, neighbour byte in the same word still updates
      wr(12'h3A0, 32'h0000_0F8F);
      wr(12'h3A0, 32'h0);
      rd_is(12'h3A0, 32'h8F, 32'h8F);
      chk_all();

      // TOR lock on entry1 protects pmpaddr0 and pmpaddr1
      do_reset();
      wr(12'h3B0, 32'hAAAA);
      wr(12'h3B1, 32'h5555);
      wr(12'h3A0, 32'h8800);
      wr(12'h3B0, 32'h1234);
      wr(12'h3B1, 32'h9999);
      wr(12'h3B2, 32'h5);
      rd_is(12'h3B0, 32'hAAAA, 32'hAAA8);
      rd_is(12'h3B1, 32'h5555, 32'h5554);
      rd_is(12'h3B2, 32'h5, 32'h4);
      chk_all();

      // W-only is illegal without MML, legal with MML
      do_reset();
      wr(12'h3A0, 32'h02);
      rd_is(12'h3A0, 32'h0, 32'h0);
      wr(12'h747, 32'h1);
      wr(12'h3A0, 32'h02);
      rd_is(12'h3A0, 32'h2, 32'h2);
      rd_is(12'h747, 32'h1, 32'h1);
      chk_all();

      // sticky MML/MMWP; RLB blocked once any entry is locked
      do_reset();
      wr(12'h747, 32'h3);
      wr(12'h747, 32'h0);
      rd_is(12'h747, 32'h3, 32'h3);
      do_reset();
      wr(12'h3A0, 32'h80);
      wr(12'h747, 32'h4);
      rd_is(12'h747, 32'h0, 32'h0);
      chk_all();

      // RLB bypasses lock and MML restrictions; clearing RLB re-arms both
      do_reset();
      wr(12'h747, 32'h5);
      wr(12'h3A0, 32'h80);
      wr(12'h3A0, 32'h8D);
      rd_is(12'h3A0, 32'h8D, 32'h8D);
      wr(12'h747, 32'h1);
      rd_is(12'h747, 32'h1, 32'h1);
      wr(12'h3A0, 32'h008D_008D);
      rd_is(12'h3A0, 32'h8D, 32'h8D);
      chk_all();

      // granularity read views and NA4 suppression
      do_reset();
      wr(12'h3A0, 32'h18);
      wr(12'h3B0, 32'h0);
      rd_is(12'h3B0, 32'h0, 32'h1);
      wr(12'h3A0, 32'h08);
      rd_is(12'h3B0, 32'h0, 32'h0);
      wr(12'h3A0, 32'h10);
      rd_is(12'h3A0, 32'h10, 32'h08);
      wr(12'h3B0, 32'hFFFF_FFFF);
      rd_is(12'h3B0, 32'hFFFF_FFFF, 32'hFFFF_FFFC);
      chk_all();

      // unimplemented entries, top entry TOR lock, 0x757, non-PMP address
      do_reset();
      wr(12'h3A1, 32'h0F0F_0F0F);
      wr(12'h3BF, 32'h1234);
      rd_is(12'h3A1, 32'h0, 32'h0F0F_0F0F);
      rd_is(12'h3BF, 32'h0, 32'h1234);
      wr(12'h3A3, 32'h8800_0000);
      wr(12'h3BE, 32'h7);
      wr(12'h3BF, 32'h99);
      rd_is(12'h3BE, 32'h0, 32'h0);
      rd_is(12'h3BF, 32'h0, 32'h1234);
      wr(12'h757, 32'h7);
      wr(12'h300, 32'hFFFF_FFFF);
      chk_rd(12'h300);
      chk_all();

      // randomized traffic with periodic asynchronous reset mid-write
      do_reset();
      for (int it = 0; it < 600; it++) begin
         if (it % 150 == 149) begin
            @(negedge clk);
            we = 1'b1;
            addr = 12'h3A0;
            wdata = $urandom;
            #2;
            rst_n = 1'b0;
            mreset();
            #1;
            chk_rd(12'h3A0);
            @(negedge clk);
            we = 1'b0;
            rst_n = 1'b1;
            chk_all();
         end
         r = $urandom_range(0, 99);
         a = (r < 35) ? 12'h3A0 + 12'($urandom_range(0, 3)) :
             (r < 75) ? 12'h3B0 + 12'($urandom_range(0, 15)) :
             (r < 80) ? 12'h747 :
             (r < 83) ? 12'h757 :
             (r < 90) ? 12'h3A4 + 12'($urandom_range(0, 11)) : 12'($urandom);
         d = $urandom;
         if (a[11:2] == 10'h0E8 && $urandom_range(0, 3) != 0) d = d & 32'h7F7F_7F7F;
         if (a == 12'h747) d = d & (($urandom_range(0, 3) == 0) ? 32'h7 : 32'h4);
         wr(a, d);
         chk_rd(a);
         chk_rd(12'h3A0 + 12'($urandom_range(0, 3)));
         chk_rd(12'h3B0 + 12'($urandom_range(0, 15)));
         if (it % 25 == 0) chk_all();
      end
      chk_all();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
